// File: rtl/load_store_unit_if.sv
// Core-side control and data-memory port bundle for the load/store unit.
// Latency: none (wiring only); the LSU registers the memory-side outputs.
// Backpressure: busy stalls the core; mem_rvalid completes the memory access.
interface load_store_unit_if #(
  parameter int ADDR_WIDTH = 32
);
  // core side
  logic                  MemRead;
  logic                  MemWrite;
  logic [2:0]            funct3;
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           wdata;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [31:0]           rdata;
  // data-memory side
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-3:0] mem_addr;
  logic [3:0]            mem_be;
  logic [31:0]           mem_wdata;
  logic [31:0]           mem_rdata;
  logic                  mem_rvalid;

  // LSU view
  modport slave (
    input  MemRead, MemWrite, funct3, addr, wdata, mem_rdata, mem_rvalid,
    output busy, done, err, rdata, mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  // core + memory view (drives requests and responses)
  modport master (
    output MemRead, MemWrite, funct3, addr, wdata, mem_rdata, mem_rvalid,
    input  busy, done, err, rdata, mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: one access at a time to a word-addressed data memory; optional WAIT timeout under LSU_TIMEOUT_EN.
// Latency: legal access >= 4 cycles acceptance-to-done; illegal access 2 cycles.
// Backpressure: busy holds the core while an access is outstanding; waits on mem_rvalid (or timeout).
module load_store_unit #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic              clk,
  input logic              rst,
  load_store_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Elaboration-time range guard on the timeout length.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("load_store_unit: TIMEOUT_CYCLES out of range 1..65535");
  end

  state_t      state_q, state_d;
  logic        req;
  logic        legal;
  logic        accept;
  logic        complete;
  logic        fail;
  logic        busy_c;
  logic        rvalid_eff;
  logic        tmo_hit;

  logic        req_q;      // high only in the first WAIT cycle
  logic        err_q;
  logic        ld_q;       // latched direction: 1 = load
  logic [1:0]  lo_q;       // latched addr[1:0]
  logic [2:0]  f3_q;       // latched funct3

  logic [3:0]  be_c;
  logic [31:0] wd_c;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  // Both MemRead and MemWrite high counts as a request so it can be rejected.
  assign req        = bus.MemRead | bus.MemWrite;
  // The response bus may still carry an old acknowledge on the request cycle.
  assign rvalid_eff = bus.mem_rvalid & ~req_q;

  // Request legality: direction must be unambiguous, funct3 valid for it, and the address naturally aligned.
  always_comb begin
    legal = 1'b0;
    if (bus.MemRead ^ bus.MemWrite) begin
      case (bus.funct3)
        3'b000:  legal = 1'b1;
        3'b100:  legal = bus.MemRead;
        3'b001:  legal = ~bus.addr[0];
        3'b101:  legal = bus.MemRead & ~bus.addr[0];
        3'b010:  legal = (bus.addr[1:0] == 2'b00);
        default: legal = 1'b0;
      endcase
    end
  end

  // Store lane replication and byte enables; loads always read the full word.
  always_comb begin
    be_c = 4'b1111;
    wd_c = 32'h0;
    if (bus.MemWrite) begin
      case (bus.funct3[1:0])
        2'b00: begin
          be_c = 4'b0001 << bus.addr[1:0];
          wd_c = {4{bus.wdata[7:0]}};
        end
        2'b01: begin
          be_c = bus.addr[1] ? 4'b1100 : 4'b0011;
          wd_c = {2{bus.wdata[15:0]}};
        end
        default: begin
          be_c = 4'b1111;
          wd_c = bus.wdata;
        end
      endcase
    end
  end

  // Lane select and sign/zero extension of the returned word using the latched offset and funct3.
  always_comb begin
    case (lo_q)
      2'd0:    ld_byte = bus.mem_rdata[7:0];
      2'd1:    ld_byte = bus.mem_rdata[15:8];
      2'd2:    ld_byte = bus.mem_rdata[23:16];
      default: ld_byte = bus.mem_rdata[31:24];
    endcase
    ld_half = lo_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (f3_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_ext = {24'h0, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_ext = {16'h0, ld_half};
      default: ld_ext = bus.mem_rdata;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  logic [15:0] tmo_cnt;

  // Count WAIT cycles without a usable response; cleared while idle so it restarts at WAIT entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= 16'h0;
    end else if (state_q != WAIT) begin
      tmo_cnt <= 16'h0;
    end else if (!rvalid_eff) begin
      tmo_cnt <= tmo_cnt + 16'd1;
    end
  end

  assign tmo_hit = (({1'b0, tmo_cnt} + 17'd1) == 17'(TIMEOUT_CYCLES));
`else
  assign tmo_hit = 1'b0;
`endif

  // State register; reset aborts any outstanding access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and control decode; a response arriving with the timeout still completes normally.
  always_comb begin
    state_d  = state_q;
    busy_c   = 1'b0;
    accept   = 1'b0;
    complete = 1'b0;
    fail     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          busy_c = 1'b1;
          if (legal) begin
            accept  = 1'b1;
            state_d = WAIT;
          end else begin
            fail    = 1'b1;
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        busy_c = 1'b1;
        if (rvalid_eff) begin
          complete = 1'b1;
          state_d  = RESP;
        end else if (tmo_hit) begin
          fail     = 1'b1;
          state_d  = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Memory request registers, latched access attributes and the load result/err flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q         <= 1'b0;
      err_q         <= 1'b0;
      ld_q          <= 1'b0;
      lo_q          <= 2'b00;
      f3_q          <= 3'b000;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_be    <= 4'h0;
      bus.mem_wdata <= 32'h0;
      bus.rdata     <= 32'h0;
    end else begin
      req_q <= accept;
      if (accept) begin
        ld_q          <= bus.MemRead;
        lo_q          <= bus.addr[1:0];
        f3_q          <= bus.funct3;
        bus.mem_we    <= bus.MemWrite;
        bus.mem_addr  <= bus.addr[ADDR_WIDTH-1:2];
        bus.mem_be    <= be_c;
        bus.mem_wdata <= wd_c;
      end
      if (fail) begin
        err_q     <= 1'b1;
        bus.rdata <= 32'h0;
      end else if (complete) begin
        err_q <= 1'b0;
        if (ld_q) begin
          bus.rdata <= ld_ext;
        end
      end
    end
  end

  assign bus.mem_req = req_q;
  assign bus.busy    = busy_c & ~rst;
  assign bus.done    = (state_q == RESP);
  assign bus.err     = (state_q == RESP) & err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: loads, stores, illegal requests, late/stale responses, reset abort.
// Latency: checks acceptance-to-done cycle counts against hand-computed values.
// Backpressure: checks busy stays high until done; timeout cases need LSU_TIMEOUT_EN.
module tb_load_store_unit;

  localparam int AW = 32;
`ifdef LSU_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 255;
`endif

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  load_store_unit_if #(.ADDR_WIDTH(AW)) bus ();

  load_store_unit #(
    .ADDR_WIDTH    (AW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  // results captured by access()
  int          r_lat;
  int          r_nreq;
  logic        r_bsy;
  logic        r_we;
  logic        r_err;
  logic        r_done2;
  logic [3:0]  r_be;
  logic [31:0] r_addr;
  logic [31:0] r_wd;
  logic [31:0] r_rdata;
  logic        seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // One access: request in cycle 0, mem_rvalid high from cycle rv_from until done.
  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] md, input int rv_from);
    r_lat = -1; r_nreq = 0; r_we = 1'b0; r_err = 1'b0; r_be = 4'h0;
    r_addr = 32'h0; r_wd = 32'h0; r_rdata = 32'h0;
    bus.MemRead = rd; bus.MemWrite = wr; bus.funct3 = f3; bus.addr = a;
    bus.wdata = wd; bus.mem_rdata = md; bus.mem_rvalid = 1'b0;
    #1;
    r_bsy = bus.busy;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      step;
      bus.MemRead = 1'b0;
      bus.MemWrite = 1'b0;
      if (bus.mem_req) begin
        r_nreq++;
        r_we = bus.mem_we; r_be = bus.mem_be; r_wd = bus.mem_wdata;
        r_addr = 32'(bus.mem_addr);
      end
      if (bus.done) begin
        r_lat = cyc; r_err = bus.err; r_rdata = bus.rdata;
        break;
      end
      if (!bus.busy) r_bsy = 1'b0;
      bus.mem_rvalid = (cyc >= rv_from);
    end
    bus.mem_rvalid = 1'b0;
    step;
    r_done2 = bus.done;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected summary");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.MemRead = 1'b0; bus.MemWrite = 1'b0; bus.funct3 = 3'b000;
    bus.addr = 32'h0; bus.wdata = 32'h0; bus.mem_rdata = 32'h0; bus.mem_rvalid = 1'b0;
    step; step;
    check("rst_busy",  32'(bus.busy),    32'h0);
    check("rst_done",  32'(bus.done),    32'h0);
    check("rst_err",   32'(bus.err),     32'h0);
    check("rst_req",   32'(bus.mem_req), 32'h0);
    check("rst_we",    32'(bus.mem_we),  32'h0);
    check("rst_rdata", bus.rdata,        32'h0);
    check("rst_maddr", 32'(bus.mem_addr), 32'h0);
    check("rst_be",    32'(bus.mem_be),  32'h0);
    check("rst_wd",    bus.mem_wdata,    32'h0);
    rst = 1'b0;
    step;

    // LB 0x103: rvalid held from first WAIT cycle, must be ignored there
    access(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF1234, 1);
    check("lb_busy0", 32'(r_bsy),  32'h1);
    check("lb_lat",   32'(r_lat),  32'd3);
    check("lb_nreq",  32'(r_nreq), 32'd1);
    check("lb_maddr", r_addr,      32'h40);
    check("lb_be",    32'(r_be),   32'hF);
    check("lb_we",    32'(r_we),   32'h0);
    check("lb_err",   32'(r_err),  32'h0);
    check("lb_rdata", r_rdata,     32'hFFFFFF80);
    check("lb_done1", 32'(r_done2), 32'h0);

    // LBU same address
    access(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF1234, 1);
    check("lbu_lat",   32'(r_lat), 32'd3);
    check("lbu_rdata", r_rdata,    32'h00000080);

    // SH 0x202: upper half lanes, rdata unchanged
    access(1'b0, 1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'hFFFFFFFF, 1);
    check("sh_lat",   32'(r_lat),  32'd3);
    check("sh_nreq",  32'(r_nreq), 32'd1);
    check("sh_we",    32'(r_we),   32'h1);
    check("sh_maddr", r_addr,      32'h80);
    check("sh_be",    32'(r_be),   32'hC);
    check("sh_wd",    r_wd,        32'hABCDABCD);
    check("sh_err",   32'(r_err),  32'h0);
    check("sh_rdata", r_rdata,     32'h00000080);

    // SB 0x001
    access(1'b0, 1'b1, 3'b000, 32'h001, 32'h7766555A, 32'h0, 2);
    check("sb_lat", 32'(r_lat), 32'd3);
    check("sb_be",  32'(r_be),  32'h2);
    check("sb_wd",  r_wd,       32'h5A5A5A5A);

    // LW misaligned: immediate error
    access(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 1);
    check("lwmis_lat",   32'(r_lat),  32'd1);
    check("lwmis_nreq",  32'(r_nreq), 32'd0);
    check("lwmis_err",   32'(r_err),  32'h1);
    check("lwmis_rdata", r_rdata,     32'h0);

    // LW aligned
    access(1'b1, 1'b0, 3'b010, 32'h104, 32'h0, 32'hDEADBEEF, 2);
    check("lw_lat",   32'(r_lat), 32'd3);
    check("lw_maddr", r_addr,     32'h41);
    check("lw_rdata", r_rdata,    32'hDEADBEEF);

    // MemRead and MemWrite both high
    access(1'b1, 1'b1, 3'b010, 32'h100, 32'h0, 32'h0, 1);
    check("both_lat",   32'(r_lat),  32'd1);
    check("both_nreq",  32'(r_nreq), 32'd0);
    check("both_err",   32'(r_err),  32'h1);
    check("both_rdata", r_rdata,     32'h0);

    // store with load-only funct3
    access(1'b0, 1'b1, 3'b100, 32'h0, 32'h0, 32'h0, 1);
    check("sbu_err", 32'(r_err), 32'h1);
    check("sbu_lat", 32'(r_lat), 32'd1);

    // LH 0x002 with late response
    access(1'b1, 1'b0, 3'b001, 32'h002, 32'h0, 32'h7FFF8001, 7);
    check("lh_lat",   32'(r_lat),  32'd8);
    check("lh_busy",  32'(r_bsy),  32'h1);
    check("lh_nreq",  32'(r_nreq), 32'd1);
    check("lh_maddr", r_addr,      32'h0);
    check("lh_rdata", r_rdata,     32'h00007FFF);

    // stale response while idle
    seen = 1'b0;
    bus.mem_rdata = 32'h12345678;
    bus.mem_rvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step;
      if (bus.done || bus.busy) seen = 1'b1;
    end
    bus.mem_rvalid = 1'b0;
    check("stale_done",  32'(seen), 32'h0);
    check("stale_rdata", bus.rdata, 32'h00007FFF);

    // reset in WAIT after mem_req
    bus.MemRead = 1'b1; bus.funct3 = 3'b010; bus.addr = 32'h200;
    step;
    bus.MemRead = 1'b0;
    check("rstw_req_pre", 32'(bus.mem_req), 32'h1);
    rst = 1'b1;
    #1;
    check("rstw_req",   32'(bus.mem_req),  32'h0);
    check("rstw_busy",  32'(bus.busy),     32'h0);
    check("rstw_done",  32'(bus.done),     32'h0);
    check("rstw_rdata", bus.rdata,         32'h0);
    check("rstw_maddr", 32'(bus.mem_addr), 32'h0);
    check("rstw_be",    32'(bus.mem_be),   32'h0);
    step;
    rst = 1'b0;
    bus.mem_rdata = 32'hCAFEF00D;
    bus.mem_rvalid = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step;
      if (bus.done) seen = 1'b1;
    end
    bus.mem_rvalid = 1'b0;
    check("rstw_nodone", 32'(seen), 32'h0);
    step;

`ifdef LSU_TIMEOUT_EN
    // no response: timeout after 4 WAIT cycles
    access(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 32'h11111111, 100);
    check("tmo_lat",   32'(r_lat), 32'd5);
    check("tmo_err",   32'(r_err), 32'h1);
    check("tmo_rdata", r_rdata,    32'h0);
    // response on the timeout cycle wins
    access(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 32'h22222222, 4);
    check("tmow_lat",   32'(r_lat), 32'd5);
    check("tmow_err",   32'(r_err), 32'h0);
    check("tmow_rdata", r_rdata,    32'h22222222);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
